// File: rtl/rgb2gray_pkg.sv
//------------------------------------------------------------------------------
// Module      : rgb2gray_pkg
// Description : Shared types and constants for the streaming grey converter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rgb2gray_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic MODE_AVG  = 1'b0;
  localparam logic MODE_LUMA = 1'b1;

  localparam int LUMA_W0    = 77;
  localparam int LUMA_W1    = 150;
  localparam int LUMA_W2    = 29;
  localparam int LUMA_SHIFT = 8;

  // Room for a full-scale sample times the largest luma weight plus a rounding term.
  function automatic int acc_width(input int color_size);
    return color_size + 8 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb2gray_const_div.sv
//------------------------------------------------------------------------------
// Module      : rgb2gray_const_div
// Description : Combinational exact floor division by a constant (DIVISOR >= 2)
//               using a reciprocal multiply followed by a single correction step.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rgb2gray_const_div #(
  parameter int IN_W    = 17,
  parameter int DIVISOR = 3
) (
  input  logic [IN_W-1:0] i_dividend,
  output logic [IN_W-1:0] o_quotient
);

  // floor(2^IN_W / D) under-estimates the quotient by at most one for any IN_W-bit input.
  localparam logic [IN_W-1:0] RECIP = IN_W'((64'd1 << IN_W) / DIVISOR);
  localparam logic [IN_W-1:0] DIV_C = IN_W'(DIVISOR);

  logic [2*IN_W-1:0] w_prod;
  logic [IN_W-1:0]   w_q0;
  logic [IN_W-1:0]   w_rem;

  assign w_prod     = {{IN_W{1'b0}}, i_dividend} * {{IN_W{1'b0}}, RECIP};
  assign w_q0       = IN_W'(w_prod >> IN_W);
  assign w_rem      = i_dividend - IN_W'(w_q0 * DIV_C);
  assign o_quotient = (w_rem >= DIV_C) ? w_q0 + IN_W'(1) : w_q0;

endmodule

`default_nettype wire

// File: rtl/rgb2gray_stream.sv
//------------------------------------------------------------------------------
// Module      : rgb2gray_stream
// Description : Accumulates CHANNELS samples per pixel and emits one grey value
//               (exact average or BT.601-style luma). Define RGB2GRAY_ROUND_EN
//               for round-to-nearest instead of truncation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rgb2gray_stream
  import rgb2gray_pkg::*;
#(
  parameter int COLOR_SIZE = 8,
  parameter int CHANNELS   = 3,
  parameter int ACC_W      = acc_width(COLOR_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic                  chan_valid_i,
  output logic                  chan_ready_o,
  input  logic [COLOR_SIZE-1:0] chan_data_i,
  output logic                  gray_valid_o,
  input  logic                  gray_ready_i,
  output logic [COLOR_SIZE-1:0] gray_data_o,
  output logic                  busy_o
);

  localparam int              IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam bit              LUMA_OK  = (CHANNELS == 3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_W-1:0]      r_acc;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_mode;
  logic [COLOR_SIZE-1:0] r_gray;

  logic                  w_xfer;
  logic                  w_first;
  logic                  w_mode_eff;
  logic [7:0]            w_weight;
  logic [ACC_W-1:0]      w_term;
  logic [ACC_W-1:0]      w_avg_num;
  logic [ACC_W-1:0]      w_luma_num;
  logic [ACC_W-1:0]      w_avg_q;
  logic [COLOR_SIZE-1:0] w_gray_calc;

  assign w_xfer     = chan_valid_i & chan_ready_o;
  assign w_first    = (r_idx == '0);
  // Mode is taken live on the first beat and from the latch for the rest of the pixel.
  assign w_mode_eff = w_first ? (LUMA_OK ? mode_i : MODE_AVG) : r_mode;

  always_comb begin
    w_weight = 8'd1;
    if (w_mode_eff == MODE_LUMA) begin
      case (r_idx)
        IDX_W'(0): w_weight = 8'(LUMA_W0);
        IDX_W'(1): w_weight = 8'(LUMA_W1);
        IDX_W'(2): w_weight = 8'(LUMA_W2);
        default:   w_weight = 8'd1;
      endcase
    end
  end

  assign w_term = ACC_W'(w_weight) * ACC_W'(chan_data_i);

`ifdef RGB2GRAY_ROUND_EN
  assign w_avg_num  = r_acc + ACC_W'(CHANNELS / 2);
  assign w_luma_num = r_acc + ACC_W'(1 << (LUMA_SHIFT - 1));
`else
  assign w_avg_num  = r_acc;
  assign w_luma_num = r_acc;
`endif

  rgb2gray_const_div #(
    .IN_W    (ACC_W),
    .DIVISOR (CHANNELS)
  ) u_div (
    .i_dividend (w_avg_num),
    .o_quotient (w_avg_q)
  );

  assign w_gray_calc = (r_mode == MODE_LUMA) ? COLOR_SIZE'(w_luma_num >> LUMA_SHIFT)
                                             : COLOR_SIZE'(w_avg_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc  <= '0;
      r_idx  <= '0;
      r_mode <= MODE_AVG;
      r_gray <= '0;
    end else begin
      if (w_xfer) begin
        r_acc <= w_first ? w_term : r_acc + w_term;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        if (w_first) begin
          r_mode <= w_mode_eff;
        end
      end
      if (r_state == CALC) begin
        r_gray <= w_gray_calc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    chan_ready_o = 1'b0;
    gray_valid_o = 1'b0;
    case (r_state)
      ACC: begin
        chan_ready_o = 1'b1;
        if (chan_valid_i && (r_idx == LAST_IDX)) begin
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_state_nxt = OUT;
      end
      OUT: begin
        gray_valid_o = 1'b1;
        if (gray_ready_i) begin
          w_state_nxt = ACC;
        end
      end
      default: begin
        w_state_nxt = ACC;
      end
    endcase
  end

  assign gray_data_o = r_gray;
  assign busy_o      = (r_idx != '0) || (r_state != ACC);

endmodule

`default_nettype wire

// File: tb/tb_rgb2gray_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_rgb2gray_stream
// Description : Directed and randomised checks of rgb2gray_stream (CHANNELS=3).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rgb2gray_stream;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       mode_i;
  logic       chan_valid_i;
  logic       chan_ready_o;
  logic [7:0] chan_data_i;
  logic       gray_valid_o;
  logic       gray_ready_i;
  logic [7:0] gray_data_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb2gray_stream #(
    .COLOR_SIZE (8),
    .CHANNELS   (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mode_i       (mode_i),
    .chan_valid_i (chan_valid_i),
    .chan_ready_o (chan_ready_o),
    .chan_data_i  (chan_data_i),
    .gray_valid_o (gray_valid_o),
    .gray_ready_i (gray_ready_i),
    .gray_data_o  (gray_data_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic m;
    int   c0;
    int   c1;
    int   c2;
    int   exp_t;
    int   exp_r;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int t, input int r);
`ifdef RGB2GRAY_ROUND_EN
    return r;
`else
    return t;
`endif
  endfunction

  function automatic int model(input logic m, input int a, input int b, input int c);
    int s;
    if (m) begin
      s = 77 * a + 150 * b + 29 * c;
`ifdef RGB2GRAY_ROUND_EN
      s = s + 128;
`endif
      return s / 256;
    end
    s = a + b + c;
`ifdef RGB2GRAY_ROUND_EN
    s = s + 1;
`endif
    return s / 3;
  endfunction

  // Called in the "#1 after posedge" phase; returns in the same phase after the accepting edge.
  task automatic push(input int d, input logic m);
    int t;
    t = 0;
    chan_valid_i = 1'b1;
    chan_data_i  = 8'(d);
    mode_i       = m;
    while (!chan_ready_o && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    if (!chan_ready_o) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    chan_valid_i = 1'b0;
  endtask

  task automatic recv(input int hold, output int data, output int lat);
    lat = 0;
    while (!gray_valid_o && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!gray_valid_o) begin
      total++;
      bad++;
      $display("FAIL recv_timeout: got valid=0 expected valid=1");
      data = -1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    data = int'(gray_data_o);
    gray_ready_i = 1'b1;
    @(posedge clk); #1;
    gray_ready_i = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d;
    int lat;
    int a, b, c, m;

    vecs[0]  = '{1'b0, 100, 100, 100, 100, 100};
    vecs[1]  = '{1'b0, 255,   0,   0,  85,  85};
    vecs[2]  = '{1'b0,   1,   1,   0,   0,   1};
    vecs[3]  = '{1'b0, 255, 255, 255, 255, 255};
    vecs[4]  = '{1'b0,  30,  60,  90,  60,  60};
    vecs[5]  = '{1'b0,  10,  11,  11,  10,  11};
    vecs[6]  = '{1'b1, 255,   0,   0,  76,  77};
    vecs[7]  = '{1'b1,   0, 255,   0, 149, 149};
    vecs[8]  = '{1'b1, 255, 255, 255, 255, 255};
    vecs[9]  = '{1'b1,   0,   0, 255,  28,  29};
    vecs[10] = '{1'b1, 100, 100, 100, 100, 100};
    vecs[11] = '{1'b1,  10,  20,  30,  18,  18};

    rst_i = 1'b1; mode_i = 1'b0; chan_valid_i = 1'b0; chan_data_i = 8'd0; gray_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_chan_ready", int'(chan_ready_o), 1);
    chk("reset_gray_valid", int'(gray_valid_o), 0);
    chk("reset_gray_data",  int'(gray_data_o),  0);
    chk("reset_busy",       int'(busy_o),       0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      push(vecs[i].c0, vecs[i].m);
      push(vecs[i].c1, vecs[i].m);
      push(vecs[i].c2, vecs[i].m);
      chk($sformatf("busy_calc[%0d]", i), int'(busy_o), 1);
      recv(0, d, lat);
      chk($sformatf("vec_data[%0d]", i), d, pick(vecs[i].exp_t, vecs[i].exp_r));
      chk($sformatf("vec_latency[%0d]", i), lat, 1);
      chk($sformatf("valid_drop[%0d]", i), int'(gray_valid_o), 0);
    end

    // Mode toggled after the first beat must not affect the pixel.
    push(255, 1'b1);
    push(0, 1'b0);
    push(0, 1'b0);
    recv(0, d, lat);
    chk("mode_toggle", d, pick(76, 77));

    // Backpressure in OUT while extra beats are offered.
    push(50, 1'b0);
    push(100, 1'b0);
    push(150, 1'b0);
    lat = 0;
    while (!gray_valid_o && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chan_valid_i = 1'b1;
    chan_data_i  = 8'd200;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid[%0d]", i), int'(gray_valid_o), 1);
      chk($sformatf("bp_data[%0d]", i), int'(gray_data_o), 100);
      chk($sformatf("bp_chan_ready[%0d]", i), int'(chan_ready_o), 0);
    end
    chan_valid_i = 1'b0;
    gray_ready_i = 1'b1;
    @(posedge clk); #1;
    gray_ready_i = 1'b0;
    chk("bp_release_valid", int'(gray_valid_o), 0);
    chk("bp_release_busy", int'(busy_o), 0);
    push(3, 1'b0);
    push(6, 1'b0);
    push(9, 1'b0);
    recv(0, d, lat);
    chk("bp_next_pixel", d, 6);

    // Reset mid-pixel discards the partial accumulation.
    push(200, 1'b0);
    push(200, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_ready", int'(chan_ready_o), 1);
    push(30, 1'b0);
    push(60, 1'b0);
    push(90, 1'b0);
    recv(0, d, lat);
    chk("rst_mid_pixel", d, 60);

    // Reset while a result waits in OUT discards it.
    push(9, 1'b1);
    push(9, 1'b1);
    push(9, 1'b1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst_out_valid", int'(gray_valid_o), 0);
    chk("rst_out_busy", int'(busy_o), 0);
    push(20, 1'b0);
    push(40, 1'b0);
    push(61, 1'b0);
    recv(0, d, lat);
    chk("rst_out_pixel", d, pick(40, 40));

    // Random pixels with random input gaps and output stalls.
    for (int p = 0; p < 400; p++) begin
      m = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      push(a, 1'(m));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      push(b, 1'($urandom_range(0, 1)));
      push(c, 1'($urandom_range(0, 1)));
      recv(int'($urandom_range(0, 3)), d, lat);
      chk($sformatf("rand[%0d] m=%0d %0d,%0d,%0d", p, m, a, b, c), d, model(1'(m), a, b, c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
